// File: rtl/des_round_ctrl.sv
// Round sequencer for an iterative DES datapath: edge-triggered start, one round per
// cycle, key-schedule shift control, and a held result under a valid/ack handshake.
module des_round_ctrl #(
  parameter int ROUNDS = 16,
  parameter int IDX_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_req,
  input  logic             mode_dec,
  input  logic             abort,
  input  logic             out_ack,
  output logic             busy,
  output logic             load_en,
  output logic             round_en,
  output logic [IDX_W-1:0] round_idx,
  output logic [1:0]       shift_amt,
  output logic             shift_dir,
  output logic             final_en,
  output logic             out_valid,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ROUND = 3'd2,
    S_FINAL = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);
  localparam logic [IDX_W-1:0] MID_IDX  = IDX_W'(8);

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic             mode_reg, mode_next;
  logic             prev_req_reg;
  logic             done_reg, done_next;
  logic             start_edge;

  assign start_edge = start_req & ~prev_req_reg;

  // prev_req resets high so a request already asserted out of reset cannot start a block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      idx_reg      <= '0;
      mode_reg     <= 1'b0;
      prev_req_reg <= 1'b1;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      mode_reg     <= mode_next;
      prev_req_reg <= start_req;
      done_reg     <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    mode_next  = mode_reg;
    case (state_reg)
      S_IDLE: begin
        // abort wins over a simultaneous edge; the edge is still consumed via prev_req
        if (!abort && start_edge) begin
          state_next = S_LOAD;
          mode_next  = mode_dec;
        end
      end
      S_LOAD: begin
        idx_next   = '0;
        state_next = abort ? S_IDLE : S_ROUND;
      end
      S_ROUND: begin
        if (abort) begin
          state_next = S_IDLE;
          idx_next   = '0;
        end else if (idx_reg == LAST_IDX) begin
          state_next = S_FINAL;
          idx_next   = '0;
        end else begin
          idx_next   = idx_reg + 1'b1;
        end
      end
      S_FINAL: begin
        state_next = abort ? S_IDLE : S_HOLD;
      end
      S_HOLD: begin
        if (out_ack || abort) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
        idx_next   = '0;
      end
    endcase
  end

  assign done_next = (state_reg == S_FINAL) && (state_next == S_HOLD);

  always_comb begin
    busy      = (state_reg != S_IDLE);
    load_en   = (state_reg == S_LOAD);
    round_en  = (state_reg == S_ROUND);
    final_en  = (state_reg == S_FINAL);
    out_valid = (state_reg == S_HOLD);
    done      = done_reg && (state_reg == S_HOLD);
    round_idx = round_en ? idx_reg : '0;
    shift_dir = busy & mode_reg;
    shift_amt = 2'd0;
    if (round_en) begin
      // decryption skips the first rotation so the right-rotates undo the encrypt schedule
      if (idx_reg == '0) begin
        shift_amt = mode_reg ? 2'd0 : 2'd1;
      end else if (idx_reg == IDX_W'(1) || idx_reg == MID_IDX || idx_reg == LAST_IDX) begin
        shift_amt = 2'd1;
      end else begin
        shift_amt = 2'd2;
      end
    end
  end

endmodule

// File: tb/tb_des_round_ctrl.sv
// Self-checking bench for des_round_ctrl: directed scenarios plus random traffic,
// compared each cycle against a phase-count model of a block's lifetime.
module tb_des_round_ctrl;

  logic       clk = 1'b0;
  logic       rst, start_req, mode_dec, abort, out_ack;
  logic       busy, load_en, round_en, shift_dir, final_en, out_valid, done;
  logic [3:0] round_idx;
  logic [1:0] shift_amt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  des_round_ctrl #(.ROUNDS(16), .IDX_W(4)) dut (
    .clk(clk), .rst(rst), .start_req(start_req), .mode_dec(mode_dec),
    .abort(abort), .out_ack(out_ack), .busy(busy), .load_en(load_en),
    .round_en(round_en), .round_idx(round_idx), .shift_amt(shift_amt),
    .shift_dir(shift_dir), .final_en(final_en), .out_valid(out_valid), .done(done)
  );

  wire [12:0] obs = {busy, load_en, round_en, round_idx, shift_amt, shift_dir,
                     final_en, out_valid, done};

  // Model: phase = cycles since an accepted edge (0 idle, 1 load, 2..17 rounds,
  // 18 final, 19 first hold cycle, 20 later hold cycles).
  int   m_phase = 0;
  logic m_mode  = 1'b0;
  logic m_prev  = 1'b1;
  int   enc_tab [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  int   dec_tab [16] = '{0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  function automatic logic [12:0] exp_vec();
    logic       b, ld, rn, fe, ov, dn, dir;
    logic [3:0] idx;
    logic [1:0] amt;
    b   = (m_phase != 0);
    ld  = (m_phase == 1);
    rn  = (m_phase >= 2) && (m_phase <= 17);
    fe  = (m_phase == 18);
    ov  = (m_phase >= 19);
    dn  = (m_phase == 19);
    idx = rn ? 4'(m_phase - 2) : 4'd0;
    amt = rn ? 2'(m_mode ? dec_tab[m_phase - 2] : enc_tab[m_phase - 2]) : 2'd0;
    dir = b & m_mode;
    return {b, ld, rn, idx, amt, dir, fe, ov, dn};
  endfunction

  task automatic model_step();
    logic e;
    if (rst) begin
      m_phase = 0; m_mode = 1'b0; m_prev = 1'b1;
    end else begin
      e = start_req & ~m_prev;
      m_prev = start_req;
      if (m_phase == 0) begin
        if (!abort && e) begin m_phase = 1; m_mode = mode_dec; end
      end else if (m_phase < 19) begin
        m_phase = abort ? 0 : m_phase + 1;
      end else begin
        m_phase = (out_ack || abort) ? 0 : 20;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_req = 1'b1; mode_dec = 1'b1; abort = 1'b0; out_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (obs !== 13'd0) begin
        errors++; $display("FAIL reset_outputs cyc=%0d obs=%h exp=0", i, obs);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++;
      if (obs !== exp_vec() || busy !== 1'b0) begin
        errors++; $display("FAIL reset_level_no_start cyc=%0d obs=%h exp=%h", i, obs, exp_vec());
      end
    end
    start_req = 1'b0; cycle();
    start_req = 1'b1; mode_dec = 1'b0; cycle();
    checks++;
    if (load_en !== 1'b1 || obs !== exp_vec()) begin
      errors++; $display("FAIL reset_then_edge obs=%h exp=%h", obs, exp_vec());
    end
    out_ack = 1'b1;
    for (int i = 0; i < 25; i++) begin
      cycle();
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL reset_block cyc=%0d obs=%h exp=%h", i, obs, exp_vec());
      end
    end
    out_ack = 1'b0; start_req = 1'b0; cycle();
  endtask

  task automatic test_block(input logic dec);
    int t_load, t_final, t_done;
    t_load = -1; t_final = -1; t_done = -1;
    start_req = 1'b1; mode_dec = dec;
    for (int t = 1; t <= 22; t++) begin
      cycle();
      start_req = 1'b0;
      mode_dec  = $urandom_range(0, 1);
      if (load_en)  t_load  = t;
      if (final_en) t_final = t;
      if (done)     t_done  = t;
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL block_%s t=%0d obs=%h exp=%h", dec ? "dec" : "enc", t, obs, exp_vec());
      end
      if (t == 21) out_ack = 1'b1;
    end
    out_ack = 1'b0;
    checks++;
    if (t_load !== 1 || t_final !== 18 || t_done !== 19 || busy !== 1'b0) begin
      errors++;
      $display("FAIL latency_%s load=%0d final=%0d done=%0d busy=%b exp 1/18/19/0",
               dec ? "dec" : "enc", t_load, t_final, t_done, busy);
    end
  endtask

  task automatic test_held_level();
    int dones;
    dones = 0;
    start_req = 1'b1; mode_dec = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (i == 8) mode_dec = 1'b1;
      out_ack = (i == 25);
      dones += int'(done);
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL held_level cyc=%0d obs=%h exp=%h", i, obs, exp_vec());
      end
    end
    out_ack = 1'b0;
    checks++;
    if (dones != 1) begin
      errors++; $display("FAIL held_level_done_count got=%0d exp=1", dones);
    end
    start_req = 1'b0; cycle();
  endtask

  task automatic test_ignore_and_hold();
    start_req = 1'b1; mode_dec = 1'b1;
    for (int i = 0; i < 19; i++) begin
      cycle();
      if (m_phase == 6) start_req = 1'b0;
      if (m_phase == 7) start_req = 1'b1;
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL ignore_edge cyc=%0d obs=%h exp=%h", i, obs, exp_vec());
      end
    end
    for (int i = 0; i < 10; i++) begin
      cycle();
      checks++;
      if (out_valid !== 1'b1 || obs !== exp_vec()) begin
        errors++; $display("FAIL hold_wait cyc=%0d obs=%h exp=%h", i, obs, exp_vec());
      end
    end
    out_ack = 1'b1; cycle(); out_ack = 1'b0;
    checks++;
    if (busy !== 1'b0 || obs !== exp_vec()) begin
      errors++; $display("FAIL hold_ack obs=%h exp=%h", obs, exp_vec());
    end
    start_req = 1'b0; cycle();
  endtask

  task automatic test_abort();
    int finals;
    finals = 0;
    start_req = 1'b1; mode_dec = 1'b0;
    for (int i = 0; i < 30 && m_phase != 9; i++) cycle();
    checks++;
    if (round_idx !== 4'd7) begin
      errors++; $display("FAIL abort_reach idx=%0d exp=7", round_idx);
    end
    abort = 1'b1; start_req = 1'b0; cycle(); abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || obs !== exp_vec()) begin
      errors++; $display("FAIL abort_idle obs=%h exp=%h", obs, exp_vec());
    end
    start_req = 1'b1; out_ack = 1'b1;
    for (int i = 0; i < 22; i++) begin
      cycle();
      finals += int'(final_en);
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL abort_restart cyc=%0d obs=%h exp=%h", i, obs, exp_vec());
      end
    end
    out_ack = 1'b0;
    checks++;
    if (finals != 1) begin
      errors++; $display("FAIL abort_restart_finals got=%0d exp=1", finals);
    end
    start_req = 1'b0; cycle();
    start_req = 1'b1; abort = 1'b1; cycle(); abort = 1'b0;
    cycle();
    checks++;
    if (busy !== 1'b0 || obs !== exp_vec()) begin
      errors++; $display("FAIL abort_idle_priority obs=%h exp=%h", obs, exp_vec());
    end
    start_req = 1'b0; cycle();
  endtask

  task automatic test_reset_mid();
    start_req = 1'b1; mode_dec = 1'b1;
    for (int i = 0; i < 30 && m_phase != 5; i++) cycle();
    checks++;
    if (round_idx !== 4'd3) begin
      errors++; $display("FAIL rst_mid_reach idx=%0d exp=3", round_idx);
    end
    rst = 1'b1; cycle(); rst = 1'b0;
    checks++;
    if (obs !== 13'd0) begin
      errors++; $display("FAIL rst_mid_outputs obs=%h exp=0", obs);
    end
    for (int i = 0; i < 4; i++) begin
      cycle();
      checks++;
      if (busy !== 1'b0 || obs !== exp_vec()) begin
        errors++; $display("FAIL rst_mid_level cyc=%0d obs=%h exp=%h", i, obs, exp_vec());
      end
    end
    start_req = 1'b0; cycle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 299) == 0);
      start_req = ($urandom_range(0, 3) != 0) ? start_req : ~start_req;
      mode_dec  = $urandom_range(0, 1);
      abort     = ($urandom_range(0, 39) == 0);
      out_ack   = ($urandom_range(0, 3) == 0);
      cycle();
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL random cyc=%0d obs=%h exp=%h", i, obs, exp_vec());
      end
    end
    rst = 1'b0; abort = 1'b0; out_ack = 1'b0; start_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_block(1'b0);
    test_block(1'b1);
    test_held_level();
    test_ignore_and_hold();
    test_abort();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
